// File: rtl/reduce_gate_pipe_pkg.sv
// rtl/reduce_gate_pipe_pkg.sv - op codes, base-op decode, identity and tree-depth helpers
package reduce_gate_pipe_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  localparam int BASE_W = 2;

  typedef enum logic [BASE_W-1:0] {
    BASE_AND  = 2'd0,
    BASE_OR   = 2'd1,
    BASE_XOR  = 2'd2,
    BASE_RSVD = 2'd3
  } base_op_e;

  // Neutral element used to pad unused tree inputs; the reserved code behaves as AND.
  function automatic logic identity(input logic [BASE_W-1:0] base);
    return (base == BASE_OR || base == BASE_XOR) ? 1'b0 : 1'b1;
  endfunction

  function automatic int ipow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int calc_levels(input int w, input int g);
    int n;
    int l;
    n = 1;
    l = 0;
    while (n < w) begin
      n = n * g;
      l = l + 1;
    end
    return (l < 1) ? 1 : l;
  endfunction

endpackage

// File: rtl/reduce_gate_pipe_node.sv
// rtl/reduce_gate_pipe_node.sv - combinational GROUP-input AND/OR/XOR tree node
module reduce_node
  import reduce_gate_pipe_pkg::*;
#(
  parameter int GROUP = 3
) (
  input  logic [GROUP-1:0]  data,
  input  logic [BASE_W-1:0] op,
  output logic              result
);

  always_comb begin
    result = &data;
    case (op)
      BASE_OR:  result = |data;
      BASE_XOR: result = ^data;
      default:  result = &data;
    endcase
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// rtl/reduce_gate_pipe.sv - pipelined WIDTH-bit logic reduction tree with valid/ready handshake
module reduce_gate_pipe
  import reduce_gate_pipe_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int GROUP = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic [2:0]       out_op
);

  localparam int LEVELS = calc_levels(WIDTH, GROUP);
  localparam int PW     = ipow(GROUP, LEVELS);

  logic          adv;
  logic [PW-1:0] pad_data;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Padding is only needed at the first level: all-pad nodes already yield the identity.
  always_comb begin
    pad_data              = {PW{identity(in_op[1:0])}};
    pad_data[WIDTH-1:0]   = in_data;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : lvl
    localparam int NIN  = ipow(GROUP, LEVELS - k);
    localparam int NOUT = NIN / GROUP;

    logic [NIN-1:0]  d_in;
    logic [2:0]      op_in;
    logic            v_in;
    logic [NOUT-1:0] node_out;
    logic [NOUT-1:0] q;
    logic [2:0]      op_q;
    logic            v_q;
    logic            inv;

    if (k == 0) begin : g_first
      assign d_in  = pad_data;
      assign op_in = in_op;
      assign v_in  = in_valid;
    end else begin : g_next
      assign d_in  = lvl[k-1].q;
      assign op_in = lvl[k-1].op_q;
      assign v_in  = lvl[k-1].v_q;
    end

    for (genvar j = 0; j < NOUT; j++) begin : node
      reduce_node #(.GROUP(GROUP)) u_node (
        .data   (d_in[j*GROUP +: GROUP]),
        .op     (op_in[1:0]),
        .result (node_out[j])
      );
    end

    // Inversion belongs to the final stage only; inner levels must stay un-inverted.
    assign inv = (k == LEVELS - 1) ? op_in[2] : 1'b0;

    always_ff @(posedge clk) begin
      if (rst) begin
        q    <= '0;
        op_q <= '0;
        v_q  <= 1'b0;
      end else if (adv) begin
        q    <= node_out ^ {NOUT{inv}};
        op_q <= op_in;
        v_q  <= v_in;
      end
    end
  end

  assign out_valid = lvl[LEVELS-1].v_q;
  assign out_data  = lvl[LEVELS-1].q[0];
  assign out_op    = lvl[LEVELS-1].op_q;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb/tb_reduce_gate_pipe.sv - scoreboard bench for reduce_gate_pipe (9,3) and (10,3)
module tb_reduce_gate_pipe;
  import reduce_gate_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_data;
  logic [8:0] a_in_data = '0;
  logic [2:0] a_in_op = '0, a_out_op;
  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_data;
  logic [9:0] b_in_data = '0;
  logic [2:0] b_in_op = '0, b_out_op;

  reduce_gate_pipe #(.WIDTH(9), .GROUP(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_op(a_in_op), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_op(a_out_op)
  );

  reduce_gate_pipe #(.WIDTH(10), .GROUP(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_op(b_in_op), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_op(b_out_op)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  int out_cyc_a[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Flat reduction from the op definition: count ones over the operand width.
  function automatic logic ref_reduce(input logic [15:0] d, input int w, input logic [2:0] op);
    int ones;
    logic r;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    case (op[1:0])
      2'd1:    r = (ones > 0);
      2'd2:    r = ones[0];
      default: r = (ones == w);
    endcase
    return r ^ op[2];
  endfunction

  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      out_cyc_a.push_back(cycle);
      if (q_a.size() == 0) check("a_unexpected_output", 1, 0);
      else begin
        logic [3:0] e;
        e = q_a.pop_front();
        check("a_out_op", int'(a_out_op), int'(e[3:1]));
        check("a_out_data", int'(a_out_data), int'(e[0]));
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) check("b_unexpected_output", 1, 0);
      else begin
        logic [3:0] e;
        e = q_b.pop_front();
        check("b_out_op", int'(b_out_op), int'(e[3:1]));
        check("b_out_data", int'(b_out_data), int'(e[0]));
      end
    end
  end

  task automatic send_a(input logic [8:0] d, input logic [2:0] op, input logic exp);
    a_in_valid = 1'b1; a_in_data = d; a_in_op = op;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (a_in_ready) begin
        q_a.push_back({op, exp});
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    check("a_accept_timeout", 0, 1);
  endtask

  task automatic send_b(input logic [9:0] d, input logic [2:0] op, input logic exp);
    b_in_valid = 1'b1; b_in_data = d; b_in_op = op;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (b_in_ready) begin
        q_b.push_back({op, exp});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    check("b_accept_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && (q_a.size() != 0 || q_b.size() != 0); t++) @(posedge clk);
    #1;
    check(name, q_a.size() + q_b.size(), 0);
  endtask

  initial begin
    logic       snap_d;
    logic [2:0] snap_op;
    int         n;
    int         base;
    logic [8:0] rd;
    logic [2:0] rop;
    logic [9:0] rdb;

    // Reset held with a pending operand
    a_in_valid = 1'b1; a_in_data = 9'h1FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_out_valid", int'(a_out_valid), 0);
      check("reset_out_data", int'(a_out_data), 0);
      check("reset_out_op", int'(a_out_op), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(a_in_ready), 1);
    check("reset_b_out_valid", int'(b_out_valid), 0);
    @(posedge clk); #1;

    // Directed ops and first-result latency
    send_a(9'h1FF, OP_AND, 1'b1);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n++;
      if (a_out_valid) break;
    end
    check("latency_levels", n, 2);
    @(posedge clk); #1;
    send_a(9'h1FE, OP_AND, 1'b0);
    send_a(9'h1FE, OP_NAND, 1'b1);
    send_a(9'h000, OP_OR, 1'b0);
    send_a(9'h100, OP_NOR, 1'b0);
    send_a(9'h0B5, OP_XOR, 1'b1);
    send_a(9'h0B5, OP_XNOR, 1'b0);
    send_a(9'h1FF, 3'd3, 1'b1);
    send_a(9'h1FF, 3'd7, 1'b0);
    drain("directed_drain");

    // Back-to-back full rate
    out_cyc_a.delete();
    for (int i = 0; i < 8; i++) begin
      rd = 9'($urandom); rop = 3'($urandom_range(0, 6));
      send_a(rd, rop, ref_reduce(16'(rd), 9, rop));
    end
    drain("b2b_drain");
    check("b2b_count", out_cyc_a.size(), 8);
    if (out_cyc_a.size() == 8) check("b2b_consecutive", out_cyc_a[7] - out_cyc_a[0], 7);

    // Backpressure with two results in flight
    a_out_ready = 1'b0;
    send_a(9'h1FF, OP_AND, 1'b1);
    send_a(9'h0B5, OP_XOR, 1'b1);
    @(negedge clk);
    snap_d = a_out_data; snap_op = a_out_op;
    check("bp_first_op", int'(snap_op), int'(OP_AND));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(a_out_valid), 1);
      check("bp_in_ready", int'(a_in_ready), 0);
      check("bp_data_stable", int'(a_out_data), int'(snap_d));
      check("bp_op_stable", int'(a_out_op), int'(snap_op));
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    drain("bp_drain");

    // Padding on the 10-bit, three-level unit
    send_b(10'h3FF, OP_AND, 1'b1);
    send_b(10'h200, OP_OR, 1'b1);
    send_b(10'h201, OP_XOR, 1'b0);
    send_b(10'h1FF, OP_NAND, 1'b1);
    drain("pad_drain");

    // Random traffic with random backpressure on both units
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          rd = 9'($urandom); rop = 3'($urandom_range(0, 7));
          if (i % 5 == 0) rd = '1;
          send_a(rd, rop, ref_reduce(16'(rd), 9, rop));
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          rdb = 10'($urandom); rop = 3'($urandom_range(0, 7));
          if (i % 7 == 0) rdb = 10'h0;
          send_b(rdb, rop, ref_reduce(16'(rdb), 10, rop));
        end
      end
      begin
        for (int i = 0; i < 400; i++) begin
          @(posedge clk); #1;
          a_out_ready = 1'($urandom);
          b_out_ready = 1'($urandom);
        end
        a_out_ready = 1'b1; b_out_ready = 1'b1;
      end
    join
    drain("random_drain");

    // Reset with two operands in flight
    base = out_cyc_a.size();
    send_a(9'h1FF, OP_AND, 1'b1);
    send_a(9'h000, OP_OR, 1'b0);
    rst = 1'b1;
    q_a.delete(); q_b.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midreset_no_output", int'(a_out_valid), 0);
    end
    check("midreset_emitted", out_cyc_a.size() - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
